output_deskew: RTL and testbench



---
 rtl/deskew_pkg.sv | 15 +
 rtl/column_delay_line.sv | 26 ++
 rtl/output_deskew.sv | 108 ++++++++++
 tb/tb_output_deskew.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/deskew_pkg.sv
// Shared types and default sizing for the systolic output deskew block.
package deskew_pkg;

   localparam int DEF_ARRAY_SIZE      = 2;
   localparam int DEF_ACC_WIDTH       = 32;
   localparam int DEF_VALID_LATENCY   = 3;
   localparam int DEF_ROW_COUNT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DONE    = 2'd2
   } deskew_state_e;

endpackage

// File: rtl/column_delay_line.sv
// Enable-gated shift register of DEPTH stages carrying one result column.
module column_delay_line #(
   parameter int DEPTH = 1,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_enable,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data
);

   logic [WIDTH-1:0] r_stage [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
      end else if (i_enable) begin
         r_stage[0] <= i_data;
         for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
      end
   end

   assign o_data = r_stage[DEPTH-1];

endmodule

// File: rtl/output_deskew.sv
// Realigns skewed array columns into whole rows and frames them against a job length.
// Optional OUTPUT_DESKEW_ZERO_INVALID_EN blanks data_out whenever out_valid is low.
module output_deskew
   import deskew_pkg::*;
#(
   parameter int ARRAY_SIZE      = DEF_ARRAY_SIZE,
   parameter int ACC_WIDTH       = DEF_ACC_WIDTH,
   parameter int VALID_LATENCY   = DEF_VALID_LATENCY,
   parameter int ROW_COUNT_WIDTH = DEF_ROW_COUNT_WIDTH
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        enable,
   input  logic                        start,
   input  logic [ROW_COUNT_WIDTH-1:0]  num_rows,
   input  logic                        a_valid,
   input  logic signed [ACC_WIDTH-1:0] data_in  [ARRAY_SIZE],
   output logic signed [ACC_WIDTH-1:0] data_out [ARRAY_SIZE],
   output logic                        out_valid,
   output logic [ROW_COUNT_WIDTH-1:0]  row_idx,
   output logic                        busy,
   output logic                        done
);

   localparam int VLD_DEPTH = VALID_LATENCY + ARRAY_SIZE;

   logic [VLD_DEPTH-1:0]        r_vld_pipe;
   logic                        w_vld_exit;
   deskew_state_e               r_state, w_state_next;
   logic [ROW_COUNT_WIDTH-1:0]  r_num_rows, w_num_rows_next;
   logic [ROW_COUNT_WIDTH-1:0]  r_row_cnt, w_row_cnt_next, w_cnt_inc;
   logic                        w_out_valid;
   logic [ACC_WIDTH-1:0]        w_col_out [ARRAY_SIZE];

   // The valid token runs in every state so rows launched before start still age out.
   always_ff @(posedge clk) begin
      if (rst)         r_vld_pipe <= '0;
      else if (enable) r_vld_pipe <= (r_vld_pipe << 1) | VLD_DEPTH'(a_valid);
   end

   assign w_vld_exit = r_vld_pipe[VLD_DEPTH-1];

   generate
      for (genvar gi = 0; gi < ARRAY_SIZE; gi++) begin : g_col
         column_delay_line #(
            .DEPTH (ARRAY_SIZE - gi),
            .WIDTH (ACC_WIDTH)
         ) u_col (
            .clk      (clk),
            .rst      (rst),
            .i_enable (enable),
            .i_data   (data_in[gi]),
            .o_data   (w_col_out[gi])
         );
`ifdef OUTPUT_DESKEW_ZERO_INVALID_EN
         assign data_out[gi] = w_out_valid ? w_col_out[gi] : '0;
`else
         assign data_out[gi] = w_col_out[gi];
`endif
      end
   endgenerate

   assign w_cnt_inc = r_row_cnt + ROW_COUNT_WIDTH'(1);

   always_comb begin
      w_state_next    = r_state;
      w_num_rows_next = r_num_rows;
      w_row_cnt_next  = r_row_cnt;
      w_out_valid     = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_num_rows_next = num_rows;
               w_row_cnt_next  = '0;
               w_state_next    = (num_rows == '0) ? DONE : COLLECT;
            end
         end
         COLLECT: begin
            if (w_vld_exit) begin
               w_out_valid    = 1'b1;
               w_row_cnt_next = w_cnt_inc;
               if (w_cnt_inc == r_num_rows) w_state_next = DONE;
            end
         end
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // A stalled out_valid stays high but only counts once, on its enable-high cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_num_rows <= '0;
         r_row_cnt  <= '0;
      end else if (enable) begin
         r_state    <= w_state_next;
         r_num_rows <= w_num_rows_next;
         r_row_cnt  <= w_row_cnt_next;
      end
   end

   assign out_valid = w_out_valid;
   assign row_idx   = r_row_cnt;
   assign busy      = (r_state == COLLECT);
   assign done      = (r_state == DONE);

endmodule

// File: tb/tb_output_deskew.sv
// Directed bench for output_deskew; honours OUTPUT_DESKEW_ZERO_INVALID_EN when defined.
module tb_output_deskew;

   localparam int AS = 2;
   localparam int AW = 32;
   localparam int VL = 3;
   localparam int RW = 8;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 enable;
   logic                 start;
   logic [RW-1:0]        num_rows;
   logic                 a_valid;
   logic signed [AW-1:0] data_in  [AS];
   logic signed [AW-1:0] data_out [AS];
   logic                 out_valid;
   logic [RW-1:0]        row_idx;
   logic                 busy;
   logic                 done;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   output_deskew #(
      .ARRAY_SIZE      (AS),
      .ACC_WIDTH       (AW),
      .VALID_LATENCY   (VL),
      .ROW_COUNT_WIDTH (RW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .start     (start),
      .num_rows  (num_rows),
      .a_valid   (a_valid),
      .data_in   (data_in),
      .data_out  (data_out),
      .out_valid (out_valid),
      .row_idx   (row_idx),
      .busy      (busy),
      .done      (done)
   );

   task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      enable     = 1'b1;
      start      = 1'b0;
      a_valid    = 1'b0;
      num_rows   = '0;
      data_in[0] = '0;
      data_in[1] = '0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_vld"},  out_valid,   0);
      check({tag, "_busy"}, busy,        0);
      check({tag, "_done"}, done,        0);
      check({tag, "_idx"},  row_idx,     0);
      check({tag, "_d0"},   data_out[0], 0);
      check({tag, "_d1"},   data_out[1], 0);
   endtask

   // Phase = enable-high edges since the job began; a row launched at phase t
   // carries column values b0+t and b1-t and must appear at phase t+5.
   task automatic run_job(input string name, input int nr,
                          input logic [63:0] av, input logic [63:0] exp_v,
                          input int done_ph, input int nph, input logic [63:0] stall,
                          input int start2_ph, input int rst_ph, input int b0, input int b1);
      int   p    = 0;
      int   w    = 0;
      int   rows = 0;
      logic ev;
      while (p < nph && w < 300) begin
         ev = exp_v[p];
         if (p == rst_ph) begin
            rst = 1'b1;
            idle_inputs();
            tick();
            rst = 1'b0;
            check_zero({name, "_rst"});
            for (int k = 0; k < 10; k++) begin
               tick();
               check({name, "_post_done"}, done,      0);
               check({name, "_post_vld"},  out_valid, 0);
               check({name, "_post_busy"}, busy,      0);
            end
            return;
         end
         check({name, "_vld"},  out_valid, ev);
         check({name, "_done"}, done, (p == done_ph));
         check({name, "_busy"}, busy, (nr != 0 && p >= 2 && p < done_ph));
         if (ev) begin
            check({name, "_idx"}, row_idx, rows);
            check({name, "_d0"},  data_out[0], b0 + p - 5);
            check({name, "_d1"},  data_out[1], b1 - (p - 5));
         end
`ifdef OUTPUT_DESKEW_ZERO_INVALID_EN
         else begin
            check({name, "_d0z"}, data_out[0], 0);
            check({name, "_d1z"}, data_out[1], 0);
         end
`endif
         enable     = !stall[w];
         start      = (p == 1) || (p == start2_ph);
         num_rows   = (p == 1) ? RW'(nr) : '0;
         a_valid    = av[p];
         data_in[0] = b0 + p - 3;
         data_in[1] = b1 - (p - 4);
         tick();
         w++;
         if (enable) begin
            if (ev) rows++;
            p++;
         end
      end
      check({name, "_timeout"}, (w >= 300), 0);
      idle_inputs();
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      repeat (3) tick();
      check_zero("reset");
      rst = 1'b0;

      for (int i = 0; i < 20; i++) begin
         data_in[0] = $urandom;
         data_in[1] = $urandom;
         tick();
         check("idle_vld",  out_valid, 0);
         check("idle_busy", busy,      0);
         check("idle_done", done,      0);
         check("idle_idx",  row_idx,   0);
`ifdef OUTPUT_DESKEW_ZERO_INVALID_EN
         check("idle_d0", data_out[0], 0);
         check("idle_d1", data_out[1], 0);
`endif
      end
      idle_inputs();
      repeat (8) tick();

      // name, nr, a_valid mask, expected out_valid mask, done phase, phases, stall mask, start2, reset phase, b0, b1
      run_job("single", 1, 64'h1 << 10, 64'h1 << 15, 16, 18, 64'h0, -1, -1, -5, 3);
      run_job("four",   4, 64'hF << 6,  64'hF << 11, 15, 17, 64'h0, -1, -1, 100, -200);
      run_job("stall",  4, 64'hF << 6,  64'hF << 11, 15, 17, 64'h7 << 12, -1, -1, 300, 50);
      run_job("zero",   0, 64'h0,       64'h0,        2,  4, 64'h0, -1, -1, 7, 9);
      run_job("restart",2, 64'h7 << 5,  64'h3 << 10, 12, 14, 64'h0,  8, -1, 1000, -1000);
      run_job("abort",  4, 64'hF << 6,  64'hF << 11, 15, 17, 64'h0, -1, 12, 40, 60);
      run_job("after",  3, 64'h7 << 4,  64'h7 << 9,  12, 14, 64'h0, -1, -1, -50, 77);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "simulation time limit reached");
   end

endmodule
